logic_unit_seq: RTL and testbench
=================================

Name: logic_unit_seq

Overview:
Parametrised, multi-cycle bitwise logic unit. It processes two WIDTH-bit operands one SLICE-bit slice per clock, LSB slice first. It supports four operations: AND, OR, XOR and NOR. It sits beside the ALU datapath as the shared logic-op engine and uses a start/busy/done handshake.

Parameters:
WIDTH, 32, operand/result width in bits; must be a multiple of SLICE.
SLICE, 8, bits processed per cycle; N = WIDTH/SLICE cycles per operation.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
start  input  1  request pulse; sampled only in IDLE or DONE
op  input  2  00 AND, 01 OR, 10 XOR, 11 NOR; latched on accept
a  input  WIDTH  operand A; latched on accept
b  input  WIDTH  operand B; latched on accept
busy  output  1  high while in RUN
done  output  1  one-cycle pulse; res is valid while done is high and until the next accept
res  output  WIDTH  result register
zero  output  1  (only with LOGIC_ZERO_FLAG_EN) res == 0, valid with done

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE, idx=0, busy=0, done=0, res=0, latched operands/op=0, zero=0.
- FSM states: IDLE, RUN, DONE.
  - IDLE --start--> RUN.
  - RUN --(idx==N-1)--> DONE.
  - DONE --start--> RUN (back-to-back accept).
  - DONE --!start--> IDLE.
- Accept (edge k, start=1 in IDLE/DONE):
  - latch a, b, op
  - res <= 0, idx <= 0, busy <= 1, done <= 0.
- RUN edge:
  - res[idx*SLICE +: SLICE] <= f(op, a_slice, b_slice); idx <= idx+1.
  - Edge k+N writes the last slice, sets busy=0 and done=1.
- Latency: done is high during the cycle after edge k+N, i.e. N cycles after accept (4 for defaults).
- start while busy=1: ignored, with no effect on latched operands or op.
- a/b/op changes after accept: no effect on the running operation.
- res holds its value in IDLE; partial slices are visible during RUN but are not valid.
- Reset asserted mid-RUN: abort immediately to reset values; no done is produced.
- idx width = clog2(N), minimum 1. N=1 (SLICE==WIDTH) is legal: done comes 1 cycle after accept.
- Bitwise ops only: no carry between slices and no sign handling.

Optional Feature:
Macro LOGIC_ZERO_FLAG_EN.
- Defined:
  - Port zero exists.
  - An accumulator nz <= nz | (|slice_result) is kept per slice and cleared on accept.
  - zero = ~nz, registered together with done; it holds until the next accept.
  - Reset value: 0.
- Undefined: no zero port and no accumulator logic.

Decomposition:
- Package logic_unit_pkg:
  - typedef op_t (2-bit)
  - constants OP_AND=2'b00, OP_OR=2'b01, OP_XOR=2'b10, OP_NOR=2'b11
  - state_t enum (IDLE, RUN, DONE)
- One sub-module: logic_slice (combinational, parameter SLICE, inputs op/a/b, output y). It is instantiated once and fed the current slice by an idx-driven mux.
- The parent holds the FSM, index counter and result register.

Test Plan:
1. Reset mid-RUN: start OR, assert rst_n=0 after 2 cycles -> busy=0, done=0, res=0 immediately; no done pulse afterwards.
2. OR, a=0xF0F0_0000, b=0x0000_0F0F, start pulse -> busy for 4 cycles, done 1 cycle, res=0xF0F0_0F0F; held after done.
3. All ops, a=0xFFFF_0000, b=0xFF00_FF00 -> AND=0xFF00_0000, OR=0xFFFF_FF00, XOR=0x00FF_FF00, NOR=0x0000_00FF.
4. start held high in RUN, with a/b changed mid-op -> single done; result uses the originally latched operands.
5. Back-to-back: start asserted in the DONE cycle -> new op accepted with no IDLE gap; second done 4 cycles later.
6. LOGIC_ZERO_FLAG_EN, AND a=0xAAAA_AAAA, b=0x5555_5555 -> res=0, zero=1. Then OR with the same operands -> res=0xFFFF_FFFF, zero=0.
7. Parameter sweep: WIDTH=16, SLICE=16 (N=1) and WIDTH=64, SLICE=4 (N=16) -> done latency equals N; randomised results match a golden bitwise model.

Source files
------------

// File: rtl/logic_unit_seq_pkg.sv
// logic_unit_pkg: shared operation codes and FSM state type for the sliced logic unit.
//   op_t    : 2-bit operation select (AND, OR, XOR, NOR)
//   state_t : sequencer states IDLE, RUN, DONE
package logic_unit_pkg;
    typedef logic [1:0] op_t;
    localparam op_t OP_AND = 2'b00;
    localparam op_t OP_OR  = 2'b01;
    localparam op_t OP_XOR = 2'b10;
    localparam op_t OP_NOR = 2'b11;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
endpackage

// File: rtl/logic_unit_seq_slice.sv
// logic_slice: combinational bitwise operator applied to one SLICE-bit chunk.
//   op : operation select (logic_unit_pkg::op_t)
//   a  : operand A slice
//   b  : operand B slice
//   y  : result slice
module logic_slice
    import logic_unit_pkg::*;
#(
    parameter int SLICE = 8
) (
    input  logic [1:0]       op,
    input  logic [SLICE-1:0] a,
    input  logic [SLICE-1:0] b,
    output logic [SLICE-1:0] y
);
    always_comb begin
        y = (op_t'(op) == OP_AND) ? (a & b) :
            (op_t'(op) == OP_OR)  ? (a | b) :
            (op_t'(op) == OP_XOR) ? (a ^ b) : ~(a | b);
    end
endmodule

// File: rtl/logic_unit_seq.sv
// logic_unit_seq: multi-cycle bitwise logic unit, one SLICE-bit chunk per clock, LSB first.
//   clk, rst_n   : rising-edge clock, asynchronous active-low reset
//   start        : request pulse, accepted only in IDLE or DONE
//   op, a, b     : operation and operands, latched on accept
//   busy         : high while slices are being processed
//   done         : one-cycle pulse; res valid from done until next accept
//   res          : result register
//   zero         : res == 0, valid with done (only when LOGIC_ZERO_FLAG_EN is defined)
module logic_unit_seq
    import logic_unit_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SLICE = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] res
`ifdef LOGIC_ZERO_FLAG_EN
    ,
    output logic             zero
`endif
);
    localparam int N  = WIDTH / SLICE;
    localparam int IW = (N > 1) ? $clog2(N) : 1;

    state_t           r_state;
    state_t           w_next;
    logic [IW-1:0]    r_idx;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    op_t              r_op;
    logic [SLICE-1:0] w_a_sl;
    logic [SLICE-1:0] w_b_sl;
    logic [SLICE-1:0] w_y;
    logic             w_accept;
    logic             w_last;

    assign w_accept = start && (r_state != RUN);
    assign w_last   = (r_idx == IW'(N - 1));
    assign w_a_sl   = r_a[r_idx*SLICE +: SLICE];
    assign w_b_sl   = r_b[r_idx*SLICE +: SLICE];
    assign busy     = (r_state == RUN);
    assign done     = (r_state == DONE);

    logic_slice #(.SLICE(SLICE)) u_slice (
        .op (r_op),
        .a  (w_a_sl),
        .b  (w_b_sl),
        .y  (w_y)
    );

    // IDLE and DONE behave identically: start launches a run, otherwise rest in IDLE
    always_comb begin
        w_next = r_state;
        w_next = (r_state == RUN) ? (w_last ? DONE : RUN) : (start ? RUN : IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_idx   <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_op    <= OP_AND;
            res     <= '0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_a   <= a;
                r_b   <= b;
                r_op  <= op_t'(op);
                res   <= '0;
                r_idx <= '0;
            end else if (r_state == RUN) begin
                res[r_idx*SLICE +: SLICE] <= w_y;
                r_idx                     <= w_last ? '0 : r_idx + 1'b1;
            end
        end
    end

`ifdef LOGIC_ZERO_FLAG_EN
    logic r_nz;

    // the final slice is folded in directly so zero lands on the same edge as done
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_nz <= 1'b0;
            zero <= 1'b0;
        end else if (w_accept) begin
            r_nz <= 1'b0;
            zero <= 1'b0;
        end else if (r_state == RUN) begin
            r_nz <= r_nz | (|w_y);
            if (w_last)
                zero <= ~(r_nz | (|w_y));
        end
    end
`endif
endmodule

// File: tb/tb_logic_unit_seq.sv
// tb_logic_unit_seq: scoreboard bench for logic_unit_seq plus N=1 and N=16 parameter sweeps.
module tb_logic_unit_seq;
    import logic_unit_pkg::*;

    localparam int LAT = 4;

    typedef struct {
        logic [31:0] res;
        logic        zero;
        int          cyc;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic [31:0] res;
    logic        zero;

    logic        st16, bz16, dn16;
    logic [1:0]  op16;
    logic [15:0] a16, b16, r16;
    logic        z16;
    logic        st64, bz64, dn64;
    logic [1:0]  op64;
    logic [63:0] a64, b64, r64;
    logic        z64;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    exp_t q[$];
    exp_t e;

    logic_unit_seq #(.WIDTH(32), .SLICE(8)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
        .busy(busy), .done(done), .res(res)
`ifdef LOGIC_ZERO_FLAG_EN
        , .zero(zero)
`endif
    );

    logic_unit_seq #(.WIDTH(16), .SLICE(16)) u16 (
        .clk(clk), .rst_n(rst_n), .start(st16), .op(op16), .a(a16), .b(b16),
        .busy(bz16), .done(dn16), .res(r16)
`ifdef LOGIC_ZERO_FLAG_EN
        , .zero(z16)
`endif
    );

    logic_unit_seq #(.WIDTH(64), .SLICE(4)) u64 (
        .clk(clk), .rst_n(rst_n), .start(st64), .op(op64), .a(a64), .b(b64),
        .busy(bz64), .done(dn64), .res(r64)
`ifdef LOGIC_ZERO_FLAG_EN
        , .zero(z64)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    function automatic logic [63:0] gold(logic [1:0] o, logic [63:0] x, logic [63:0] y);
        case (o)
            2'b00:   return x & y;
            2'b01:   return x | y;
            2'b10:   return x ^ y;
            default: return ~(x | y);
        endcase
    endfunction

    task automatic chk(string nm, logic [63:0] act, logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, req);
        end
    endtask

    // scoreboard monitor: every done pulse must match the oldest pending expectation
    always @(negedge clk) begin
        if (rst_n && done) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done res=%0h", res);
            end else begin
                e = q.pop_front();
                chk("res", {32'h0, res}, {32'h0, e.res});
                chk("latency", 64'(cyc - e.cyc), 64'(LAT));
`ifdef LOGIC_ZERO_FLAG_EN
                chk("zero", {63'h0, zero}, {63'h0, e.zero});
`endif
            end
        end
    end

    task automatic issue(logic [1:0] o, logic [31:0] x, logic [31:0] y, logic [31:0] r, bit hold);
        exp_t n;
        start = 1'b1;
        op    = o;
        a     = x;
        b     = y;
        @(posedge clk);
        #1;
        n.res  = r;
        n.zero = (r == 32'h0);
        n.cyc  = cyc;
        q.push_back(n);
        a = ~x;
        b = ~y;
        op = ~o;
        if (!hold) start = 1'b0;
    endtask

    task automatic wait_done();
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done) return;
        end
        checks++;
        errors++;
        $display("FAIL done_timeout actual=0 required=1");
    endtask

    logic [1:0]  ops3 [4] = '{OP_AND, OP_OR, OP_XOR, OP_NOR};
    logic [31:0] exp3 [4] = '{32'hFF00_0000, 32'hFFFF_FF00, 32'h00FF_FF00, 32'h0000_00FF};

    initial begin
        int n;
        logic [63:0] sa, sb;
        rst_n = 1'b0; start = 1'b0; op = 2'b00; a = '0; b = '0;
        st16 = 1'b0; op16 = 2'b00; a16 = '0; b16 = '0;
        st64 = 1'b0; op64 = 2'b00; a64 = '0; b64 = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", {63'h0, busy}, 64'h0);
        chk("rst_done", {63'h0, done}, 64'h0);
        chk("rst_res", {32'h0, res}, 64'h0);
`ifdef LOGIC_ZERO_FLAG_EN
        chk("rst_zero", {63'h0, zero}, 64'h0);
`endif
        @(negedge clk) rst_n = 1'b1;

        // reset mid-run: abort, nothing pending, so any later done is flagged by the monitor
        @(negedge clk);
        start = 1'b1; op = OP_OR; a = 32'hF0F0_0000; b = 32'h0000_0F0F;
        @(posedge clk);
        #1 start = 1'b0;
        chk("mid_busy", {63'h0, busy}, 64'h1);
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b0;
        #1;
        chk("abort_busy", {63'h0, busy}, 64'h0);
        chk("abort_done", {63'h0, done}, 64'h0);
        chk("abort_res", {32'h0, res}, 64'h0);
        @(negedge clk) rst_n = 1'b1;
        repeat (8) @(negedge clk);

        // basic OR with hold check afterwards
        issue(OP_OR, 32'hF0F0_0000, 32'h0000_0F0F, 32'hF0F0_0F0F, 1'b0);
        chk("or_busy", {63'h0, busy}, 64'h1);
        wait_done();
        repeat (3) @(negedge clk);
        chk("or_hold_res", {32'h0, res}, 64'hF0F0_0F0F);
        chk("or_hold_done", {63'h0, done}, 64'h0);
        chk("or_hold_busy", {63'h0, busy}, 64'h0);

        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            issue(ops3[i], 32'hFFFF_0000, 32'hFF00_FF00, exp3[i], 1'b0);
            wait_done();
        end

        // start held and operands changed during the run
        @(negedge clk);
        issue(OP_XOR, 32'h1234_5678, 32'h0F0F_0F0F, 32'h1D3B_5977, 1'b1);
        a = 32'hFFFF_FFFF; b = 32'h0; op = OP_AND;
        repeat (3) @(posedge clk);
        #1 start = 1'b0;
        wait_done();
        repeat (4) @(negedge clk);

        // back-to-back accept from the DONE cycle
        issue(OP_AND, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 1'b0);
        wait_done();
        issue(OP_NOR, 32'h0000_FFFF, 32'h00FF_0000, 32'hFF00_0000, 1'b0);
        chk("b2b_busy", {63'h0, busy}, 64'h1);
        wait_done();

        @(negedge clk);
        issue(OP_AND, 32'hAAAA_AAAA, 32'h5555_5555, 32'h0, 1'b0);
        wait_done();
        @(negedge clk);
`ifdef LOGIC_ZERO_FLAG_EN
        chk("zero_hold", {63'h0, zero}, 64'h1);
`endif
        issue(OP_OR, 32'hAAAA_AAAA, 32'h5555_5555, 32'hFFFF_FFFF, 1'b0);
        wait_done();

        // parameter sweep N=1
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            sa = {$urandom, $urandom}; sb = {$urandom, $urandom};
            st16 = 1'b1; op16 = 2'(i); a16 = sa[15:0]; b16 = sb[15:0];
            @(posedge clk);
            #1 st16 = 1'b0; a16 = ~a16;
            n = 0;
            do begin @(posedge clk); #1 n++; end while (!dn16 && n < 40);
            chk("lat16", 64'(n), 64'd1);
            chk("res16", {48'h0, r16}, {48'h0, gold(2'(i), {48'h0, sa[15:0]}, {48'h0, sb[15:0]}) & 64'hFFFF});
        end

        // parameter sweep N=16
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            sa = {$urandom, $urandom}; sb = {$urandom, $urandom};
            st64 = 1'b1; op64 = 2'(3 - i); a64 = sa; b64 = sb;
            @(posedge clk);
            #1 st64 = 1'b0; b64 = ~b64;
            n = 0;
            do begin @(posedge clk); #1 n++; end while (!dn64 && n < 40);
            chk("lat64", 64'(n), 64'd16);
            chk("res64", r64, gold(2'(3 - i), sa, sb));
        end

        repeat (10) @(negedge clk);
        chk("queue_empty", 64'(q.size()), 64'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
